// File: rtl/dmem_wbuf.sv
// dmem_wbuf: posted-store write buffer between the core data port and a
// slow, handshaked data memory. Stores are queued in a circular FIFO and
// drained in order by a background FSM. Loads are forwarded from the youngest
// matching buffered store, or else stall the core while memory is read.
// Optional build macro WBUF_COALESCE_EN: a store hitting a buffered word
// (other than the one currently being written) overwrites it in place.
module dmem_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RDONE = 2'd3;

  logic [29:0]   idx_r  [DEPTH];
  logic [31:0]   data_r [DEPTH];
  logic [AW-1:0] head_r, tail_r;
  logic [AW:0]   count_r;
  logic [1:0]    state_r;
  logic          mem_req_r, mem_we_r;
  logic [31:0]   mem_addr_r, mem_wdata_r, rdata_q_r;

  logic          hit_s, co_hit_s, ld_miss_s, wr_en_s, alloc_s, pop_s;
  logic [31:0]   hit_data_s, nxt_data_s;
  logic [AW-1:0] co_slot_s, wr_slot_s, nxt_slot_s;
  logic          unused_s;

  assign unused_s = ^cpu_addr[1:0];

  // Load forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [AW-1:0] slot_v;
    hit_s      = 1'b0;
    hit_data_s = 32'd0;
    slot_v     = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      slot_v = head_r + k[AW-1:0];
      if ((k < int'(count_r)) && (idx_r[slot_v] == cpu_addr[31:2])) begin
        hit_s      = 1'b1;
        hit_data_s = data_r[slot_v];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  // Store coalescing target: youngest match, skipping the entry being written.
  always_comb begin
    logic [AW-1:0] slot_v;
    co_hit_s  = 1'b0;
    co_slot_s = tail_r;
    slot_v    = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      slot_v = head_r + k[AW-1:0];
      if ((k < int'(count_r)) && !((k == 0) && (state_r == WRITE)) &&
          (idx_r[slot_v] == cpu_addr[31:2]) && cpu_we) begin
        co_hit_s  = 1'b1;
        co_slot_s = slot_v;
      end else begin
        co_hit_s  = co_hit_s;
      end
    end
  end
`else
  // Coalescing disabled: every store allocates a fresh entry.
  always_comb begin
    co_hit_s  = 1'b0;
    co_slot_s = tail_r;
  end
`endif

  // Core-side handshake, buffer write/pop strobes and next-head data forwarding.
  always_comb begin
    ld_miss_s = cpu_re && !cpu_we && !hit_s;
    wr_en_s   = cpu_we && (co_hit_s || (count_r != CNT_FULL));
    alloc_s   = cpu_we && !co_hit_s && (count_r != CNT_FULL);
    wr_slot_s = co_hit_s ? co_slot_s : tail_r;
    pop_s     = (state_r == WRITE) && mem_req_r && mem_ack;
    if (cpu_we) begin
      cpu_stall = (count_r == CNT_FULL) && !co_hit_s;
    end else if (cpu_re) begin
      cpu_stall = !hit_s && (state_r != RDONE);
    end else begin
      cpu_stall = 1'b0;
    end
    if (state_r == RDONE) begin
      cpu_rdata = rdata_q_r;
    end else if (hit_s) begin
      cpu_rdata = hit_data_s;
    end else begin
      cpu_rdata = rdata_q_r;
    end
    // Entry that will be presented next; a same-cycle coalesce into it must win.
    nxt_slot_s = (state_r == WRITE) ? (head_r + PTR_ONE) : head_r;
    if (wr_en_s && (wr_slot_s == nxt_slot_s)) begin
      nxt_data_s = cpu_wdata;
    end else begin
      nxt_data_s = data_r[nxt_slot_s];
    end
  end

  // Entry storage: contents need no reset, validity comes from count_r.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      idx_r[wr_slot_s]  <= cpu_addr[31:2];
      data_r[wr_slot_s] <= cpu_wdata;
    end
  end

  // FIFO pointers and occupancy; a store and a pop together leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      if (pop_s)   head_r <= head_r + PTR_ONE;
      if (alloc_s) tail_r <= tail_r + PTR_ONE;
      count_r <= count_r + {{AW{1'b0}}, alloc_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Drain/read FSM with registered memory-side outputs held until ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      rdata_q_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ld_miss_s) begin
            state_r    <= READ;
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {cpu_addr[31:2], 2'b00};
          end else if (count_r != CNT_ZERO) begin
            state_r     <= WRITE;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= {idx_r[nxt_slot_s], 2'b00};
            mem_wdata_r <= nxt_data_s;
          end else begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            if (ld_miss_s) begin
              state_r    <= READ;
              mem_req_r  <= 1'b1;
              mem_we_r   <= 1'b0;
              mem_addr_r <= {cpu_addr[31:2], 2'b00};
            end else if (count_r > CNT_ONE) begin
              state_r     <= WRITE;
              mem_req_r   <= 1'b1;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= {idx_r[nxt_slot_s], 2'b00};
              mem_wdata_r <= nxt_data_s;
            end else begin
              state_r   <= IDLE;
              mem_req_r <= 1'b0;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            rdata_q_r <= mem_rdata;
            mem_req_r <= 1'b0;
            state_r   <= RDONE;
          end
        end
        RDONE: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed, table-driven bench for dmem_wbuf. Inputs change on the falling
// edge and outputs are sampled 1 ns later, well before the next rising edge.
`timescale 1ns/1ps
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0, cpu_re = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

`ifdef WBUF_COALESCE_EN
  localparam logic [31:0] FIRST_WD = 32'h0000_BBBB;
  localparam int          EXP_NWR  = 1;
`else
  localparam logic [31:0] FIRST_WD = 32'h0000_AAAA;
  localparam int          EXP_NWR  = 2;
`endif

  dmem_wbuf #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, we, re;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] mrd;
    logic        e_stall, e_rchk;
    logic [31:0] e_rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, we, re, input logic [31:0] addr, wdata,
                     input logic ack, input logic [31:0] mrd,
                     input logic e_stall, e_rchk, input logic [31:0] e_rdata,
                     input logic e_req, e_we, input logic [31:0] e_addr, e_wd);
    vec_t t;
    t.rst = rst; t.we = we; t.re = re; t.addr = addr; t.wdata = wdata;
    t.ack = ack; t.mrd = mrd; t.e_stall = e_stall; t.e_rchk = e_rchk;
    t.e_rdata = e_rdata; t.e_req = e_req; t.e_we = e_we;
    t.e_addr = e_addr; t.e_wd = e_wd;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int i);
    vec_t t;
    t = vecs[i];
    @(negedge clk);
    reset = t.rst; cpu_we = t.we; cpu_re = t.re; cpu_addr = t.addr;
    cpu_wdata = t.wdata; mem_ack = t.ack; mem_rdata = t.mrd;
    #1;
    chk("cpu_stall", i, {31'd0, cpu_stall}, {31'd0, t.e_stall});
    chk("mem_req", i, {31'd0, mem_req}, {31'd0, t.e_req});
    if (t.e_req) begin
      chk("mem_we", i, {31'd0, mem_we}, {31'd0, t.e_we});
      chk("mem_addr", i, mem_addr, t.e_addr);
      if (t.e_we) chk("mem_wdata", i, mem_wdata, t.e_wd);
    end
    if (t.e_rchk) chk("cpu_rdata", i, cpu_rdata, t.e_rdata);
  endtask

  initial begin
    int split;
    int n_wr;
    logic [31:0] first_wd, last_wd;

    // Buffer fills with ack low; fifth store stalls until the first pop.
    add(0,1,0,32'h10,32'hD000_0010,0,0, 0,0,0, 0,0,0,0);
    add(0,1,0,32'h14,32'hD000_0014,0,0, 0,0,0, 0,0,0,0);
    add(0,1,0,32'h18,32'hD000_0018,0,0, 0,0,0, 1,1,32'h10,32'hD000_0010);
    add(0,1,0,32'h1C,32'hD000_001C,0,0, 0,0,0, 1,1,32'h10,32'hD000_0010);
    add(0,1,0,32'h20,32'hD000_0020,0,0, 1,0,0, 1,1,32'h10,32'hD000_0010);
    add(0,1,0,32'h20,32'hD000_0020,1,0, 1,0,0, 1,1,32'h10,32'hD000_0010);
    add(0,1,0,32'h20,32'hD000_0020,1,0, 0,0,0, 1,1,32'h14,32'hD000_0014);
    add(0,0,0,32'h0, 32'h0,        1,0, 0,0,0, 1,1,32'h18,32'hD000_0018);
    add(0,0,0,32'h0, 32'h0,        1,0, 0,0,0, 1,1,32'h1C,32'hD000_001C);
    add(0,0,0,32'h0, 32'h0,        1,0, 0,0,0, 1,1,32'h20,32'hD000_0020);
    add(0,0,0,32'h0, 32'h0,        0,0, 0,0,0, 0,0,0,0);
    // Two stores to one word, then a forwarded load of the younger data.
    add(0,1,0,32'h40,32'h0000_AAAA,0,0, 0,0,0, 0,0,0,0);
    add(0,1,0,32'h40,32'h0000_BBBB,0,0, 0,0,0, 0,0,0,0);
    add(0,0,1,32'h40,32'h0,        0,0, 0,1,32'h0000_BBBB, 1,1,32'h40,FIRST_WD);
    split = vecs.size();
    // Load miss on an empty buffer, ack three cycles after the request.
    add(0,0,1,32'h80,0,0,0,            1,0,0, 0,0,0,0);
    add(0,0,1,32'h80,0,0,0,            1,0,0, 1,0,32'h80,0);
    add(0,0,1,32'h80,0,0,0,            1,0,0, 1,0,32'h80,0);
    add(0,0,1,32'h80,0,0,0,            1,0,0, 1,0,32'h80,0);
    add(0,0,1,32'h80,0,1,32'h1234_5678,1,0,0, 1,0,32'h80,0);
    add(0,0,1,32'h80,0,0,0,            0,1,32'h1234_5678, 0,0,0,0);
    add(0,0,0,32'h0, 0,0,0,            0,0,0, 0,0,0,0);
    // Load miss while a write is in flight with two more queued.
    add(0,1,0,32'h100,32'hA1,0,0,          0,0,0, 0,0,0,0);
    add(0,1,0,32'h104,32'hA2,0,0,          0,0,0, 0,0,0,0);
    add(0,1,0,32'h108,32'hA3,0,0,          0,0,0, 1,1,32'h100,32'hA1);
    add(0,0,1,32'h200,0,0,0,               1,0,0, 1,1,32'h100,32'hA1);
    add(0,0,1,32'h200,0,1,0,               1,0,0, 1,1,32'h100,32'hA1);
    add(0,0,1,32'h200,0,0,0,               1,0,0, 1,0,32'h200,0);
    add(0,0,1,32'h200,0,1,32'hCAFE_F00D,   1,0,0, 1,0,32'h200,0);
    add(0,0,1,32'h200,0,0,0,               0,1,32'hCAFE_F00D, 0,0,0,0);
    add(0,0,0,32'h0,  0,0,0,               0,0,0, 0,0,0,0);
    add(0,0,0,32'h0,  0,1,0,               0,0,0, 1,1,32'h104,32'hA2);
    add(0,0,0,32'h0,  0,1,0,               0,0,0, 1,1,32'h108,32'hA3);
    add(0,0,0,32'h0,  0,0,0,               0,0,0, 0,0,0,0);
    // Reset mid-write discards pending stores; the same address then misses.
    add(0,1,0,32'h300,32'hB1,0,0,          0,0,0, 0,0,0,0);
    add(0,1,0,32'h304,32'hB2,0,0,          0,0,0, 0,0,0,0);
    add(0,1,0,32'h308,32'hB3,0,0,          0,0,0, 1,1,32'h300,32'hB1);
    add(0,0,0,32'h0,  0,0,0,               0,0,0, 1,1,32'h300,32'hB1);
    add(1,0,0,32'h0,  0,0,0,               0,0,0, 0,0,0,0);
    add(0,0,1,32'h300,0,0,0,               1,0,0, 0,0,0,0);
    add(0,0,1,32'h300,0,0,0,               1,0,0, 1,0,32'h300,0);
    add(0,0,1,32'h300,0,1,32'h77,          1,0,0, 1,0,32'h300,0);
    add(0,0,1,32'h300,0,0,0,               0,1,32'h77, 0,0,0,0);
    add(0,0,0,32'h0,  0,0,0,               0,0,0, 0,0,0,0);
    add(0,0,0,32'h0,  0,0,0,               0,0,0, 0,0,0,0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req",   -1, {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",    -1, {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr",  -1, mem_addr, 32'd0);
    chk("rst_mem_wdata", -1, mem_wdata, 32'd0);
    chk("rst_cpu_stall", -1, {31'd0, cpu_stall}, 32'd0);
    chk("rst_cpu_rdata", -1, cpu_rdata, 32'd0);

    for (int i = 0; i < split; i++) apply(i);

    // Drain the two same-word stores and count the memory writes issued.
    n_wr = 0; first_wd = 32'd0; last_wd = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cpu_re = 1'b0; cpu_we = 1'b0; mem_ack = 1'b1;
      #1;
      if (mem_req && mem_we) begin
        if (n_wr == 0) first_wd = mem_wdata;
        last_wd = mem_wdata;
        n_wr++;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("same_word_write_count", split, n_wr, EXP_NWR);
    chk("same_word_first_data",  split, first_wd, FIRST_WD);
    chk("same_word_last_data",   split, last_wd, 32'h0000_BBBB);

    for (int i = split; i < vecs.size(); i++) apply(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
